// File: rtl/pll_mgmt_if.sv
// Avalon-MM write-only link between the PAL/NTSC sequencer and the PLL reconfiguration controller.
// The master raises mgmt_write with address/data and holds all three stable while mgmt_waitrequest=1; a write completes on the first rising edge with mgmt_write=1 and mgmt_waitrequest=0.
interface pll_mgmt_if;
   logic        mgmt_waitrequest;
   logic        mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;

   modport master (
      input  mgmt_waitrequest,
      output mgmt_write,
      output mgmt_address,
      output mgmt_writedata
   );

   modport slave (
      output mgmt_waitrequest,
      input  mgmt_write,
      input  mgmt_address,
      input  mgmt_writedata
   );
endinterface

// File: rtl/pll_mode_switcher.sv
// Reprograms the video/system fractional PLL whenever the core's PAL flag changes.
// Define PLL_LOCK_WAIT_EN to replace the fixed settle delay with an unlock/re-lock wait plus timeout.
module pll_mode_switcher #(
   parameter int          SYNC_STAGES   = 2,
   parameter logic [31:0] FRAC_PAL      = 32'h15448515,
   parameter logic [31:0] FRAC_NTSC     = 32'h29E2B79B,
   parameter int          SETTLE_CYCLES = 1024,
   parameter int          LOCK_TIMEOUT  = 65535
) (
   input  logic        CLK_50M,
   input  logic        reset,
   input  logic        pal,
   input  logic        pll_locked,
   pll_mgmt_if.master  mgmt,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        cur_mode,
   output logic        hold_en,
   output logic [2:0]  dbg_state
);

   localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WR_MODE     = 3'd1,
      WR_FRAC     = 3'd2,
      WR_START    = 3'd3,
      SETTLE      = 3'd4,
      WAIT_UNLOCK = 3'd5,
      WAIT_LOCK   = 3'd6,
      DONE        = 3'd7
   } state_t;

   state_t          state, state_n;
   logic            gap, gap_n;
   logic [CW-1:0]   cnt, cnt_n, cnt_inc;
   logic            pending, pending_n;
   logic            tgt, tgt_n;
   logic            timeout_n;
   logic            cur_mode_n;
   logic            xfer;

   // Synchronisers are deliberately outside reset so a reset never fakes a mode edge.
   logic [SYNC_STAGES-1:0] pal_sync;
   logic                   pal_s;

   always_ff @(posedge CLK_50M) begin
      pal_sync <= {pal_sync[SYNC_STAGES-2:0], pal};
   end
   assign pal_s = pal_sync[SYNC_STAGES-1];

`ifdef PLL_LOCK_WAIT_EN
   localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_TIMEOUT);
   logic [1:0] lock_sync;
   logic       lock_s;

   always_ff @(posedge CLK_50M) begin
      lock_sync <= {lock_sync[0], pll_locked};
   end
   assign lock_s = lock_sync[1];
`else
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   logic unused_lock;
   assign unused_lock = pll_locked;
`endif

   assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
   assign dbg_state = state;

   always_ff @(posedge CLK_50M) begin
      if (reset) begin
         state    <= IDLE;
         gap      <= 1'b0;
         cnt      <= '0;
         pending  <= 1'b0;
         tgt      <= 1'b0;
         timeout  <= 1'b0;
         cur_mode <= 1'b0;
      end else begin
         state    <= state_n;
         gap      <= gap_n;
         cnt      <= cnt_n;
         pending  <= pending_n;
         tgt      <= tgt_n;
         timeout  <= timeout_n;
         cur_mode <= cur_mode_n;
      end
   end

   always_comb begin
      state_n             = state;
      gap_n               = 1'b0;
      cnt_n               = cnt;
      pending_n           = pending;
      tgt_n               = tgt;
      timeout_n           = timeout;
      cur_mode_n          = cur_mode;
      mgmt.mgmt_write     = 1'b0;
      mgmt.mgmt_address   = 6'd0;
      mgmt.mgmt_writedata = 32'd0;
      busy                = 1'b0;
      hold_en             = 1'b0;
      done                = 1'b0;
      xfer                = 1'b0;

      case (state)
         IDLE: begin
            if (pending) begin
               tgt_n     = pal_s;
               pending_n = 1'b0;
               timeout_n = 1'b0;
               state_n   = WR_MODE;
            end else begin
               pending_n = (pal_s != cur_mode);
            end
         end
         WR_MODE: begin
            busy                = 1'b1;
            hold_en             = 1'b1;
            mgmt.mgmt_write     = !gap;
            mgmt.mgmt_address   = 6'd0;
            xfer                = mgmt.mgmt_write && !mgmt.mgmt_waitrequest;
            if (xfer) begin
               gap_n   = 1'b1;
               state_n = WR_FRAC;
            end
         end
         WR_FRAC: begin
            busy                = 1'b1;
            hold_en             = 1'b1;
            mgmt.mgmt_write     = !gap;
            mgmt.mgmt_address   = 6'd7;
            mgmt.mgmt_writedata = tgt ? FRAC_PAL : FRAC_NTSC;
            xfer                = mgmt.mgmt_write && !mgmt.mgmt_waitrequest;
            if (xfer) begin
               gap_n   = 1'b1;
               state_n = WR_START;
            end
         end
         WR_START: begin
            busy                = 1'b1;
            hold_en             = 1'b1;
            mgmt.mgmt_write     = !gap;
            mgmt.mgmt_address   = 6'd2;
            xfer                = mgmt.mgmt_write && !mgmt.mgmt_waitrequest;
            if (xfer) begin
               cnt_n = '0;
`ifdef PLL_LOCK_WAIT_EN
               state_n = WAIT_UNLOCK;
`else
               state_n = SETTLE;
`endif
            end
         end
`ifdef PLL_LOCK_WAIT_EN
         WAIT_UNLOCK: begin
            busy    = 1'b1;
            hold_en = 1'b1;
            if (!lock_s) begin
               cnt_n   = '0;
               state_n = WAIT_LOCK;
            end else if (cnt == LOCK_LIMIT) begin
               timeout_n = 1'b1;
               state_n   = DONE;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         WAIT_LOCK: begin
            busy    = 1'b1;
            hold_en = 1'b1;
            if (lock_s) begin
               state_n = DONE;
            end else if (cnt == LOCK_LIMIT) begin
               timeout_n = 1'b1;
               state_n   = DONE;
            end else begin
               cnt_n = cnt_inc;
            end
         end
`else
         SETTLE: begin
            busy    = 1'b1;
            hold_en = 1'b1;
            if (cnt == SETTLE_LAST) begin
               state_n = DONE;
            end else begin
               cnt_n = cnt_inc;
            end
         end
`endif
         DONE: begin
            done       = 1'b1;
            cur_mode_n = tgt;
            // A request that changed mid-sequence is replayed straight away.
            pending_n  = (pal_s != tgt);
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
